// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter sharing one data_memory port; one transaction in flight at a time.
// Define ARB_FIXED_PRIORITY_EN for fixed req0-first priority (default: round-robin).
module data_mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clk_enable_i,
    input  logic              rd0_i,
    input  logic              wr0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    output logic              ack0_o,
    output logic [DATA_W-1:0] rdata0_o,
    input  logic              rd1_i,
    input  logic              wr1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              ack1_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [DATA_W-1:0] mem_writedata_o,
    input  logic [DATA_W-1:0] mem_readdata_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic act0, act1, pick1;

    assign act0 = rd0_i | wr0_i;
    assign act1 = rd1_i | wr1_i;

`ifdef ARB_FIXED_PRIORITY_EN
    assign pick1 = act1 & ~act0;
`else
    logic last_grant_q;

    // Reset to 1 so req0 wins the first contended grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_grant_q <= 1'b1;
        end else if (clk_enable_i && (state_q == StDone)) begin
            last_grant_q <= grant_q;
        end
    end

    assign pick1 = act1 & (~act0 | ~last_grant_q);
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            StIdle: begin
                if (act0 || act1) begin
                    state_d = StIssue;
                    grant_d = pick1;
                    // rd&wr together is treated as a write
                    write_d = pick1 ? wr1_i : wr0_i;
                    addr_d  = pick1 ? addr1_i : addr0_i;
                    wdata_d = pick1 ? wdata1_i : wdata0_i;
                end
            end
            StIssue: state_d = write_q ? StDone : StWait;
            StWait: begin
                state_d = StDone;
                if (grant_q) rdata1_d = mem_readdata_i;
                else         rdata0_d = mem_readdata_i;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            grant_q  <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else if (clk_enable_i) begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Latched address/data only change on grant, so they hold outside ISSUE.
    assign mem_address_o   = addr_q;
    assign mem_writedata_o = wdata_q;
    assign mem_read_o      = (state_q == StIssue) & ~write_q;
    assign mem_write_o     = (state_q == StIssue) & write_q;
    assign ack0_o          = (state_q == StDone) & ~grant_q;
    assign ack1_o          = (state_q == StDone) & grant_q;
    assign rdata0_o        = rdata0_q;
    assign rdata1_o        = rdata1_q;
    assign busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small registered-read memory model.
// Honours ARB_FIXED_PRIORITY_EN for the contended-grant expectations.
module tb_data_mem_arbiter;

    logic        clk_i, rst_ni, clk_enable_i;
    logic        rd0_i, wr0_i, rd1_i, wr1_i;
    logic [31:0] addr0_i, wdata0_i, addr1_i, wdata1_i;
    logic        ack0_o, ack1_o;
    logic [31:0] rdata0_o, rdata1_o;
    logic [31:0] mem_address_o, mem_writedata_o, mem_readdata_i;
    logic        mem_read_o, mem_write_o, busy_o;

    logic [31:0] mem [64];
    int          checks = 0;
    int          errors = 0;

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .clk_enable_i    (clk_enable_i),
        .rd0_i           (rd0_i),
        .wr0_i           (wr0_i),
        .addr0_i         (addr0_i),
        .wdata0_i        (wdata0_i),
        .ack0_o          (ack0_o),
        .rdata0_o        (rdata0_o),
        .rd1_i           (rd1_i),
        .wr1_i           (wr1_i),
        .addr1_i         (addr1_i),
        .wdata1_i        (wdata1_i),
        .ack1_o          (ack1_o),
        .rdata1_o        (rdata1_o),
        .mem_address_o   (mem_address_o),
        .mem_read_o      (mem_read_o),
        .mem_write_o     (mem_write_o),
        .mem_writedata_o (mem_writedata_o),
        .mem_readdata_i  (mem_readdata_i),
        .busy_o          (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Word-addressed memory; read data appears the cycle after mem_read.
    always @(posedge clk_i) begin
        if (mem_write_o) mem[mem_address_o[7:2]] <= mem_writedata_o;
        if (mem_read_o)  mem_readdata_i <= mem[mem_address_o[7:2]];
    end

    always @(negedge clk_i) begin
        checks++;
        assert (!(ack0_o && ack1_o)) else begin
            errors++;
            $error("FAIL both_acks: got ack0=%0b ack1=%0b want not both 1", ack0_o, ack1_o);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack0"}, {31'd0, ack0_o}, 32'd0);
        chk({tag, "_ack1"}, {31'd0, ack1_o}, 32'd0);
        chk({tag, "_mrd"}, {31'd0, mem_read_o}, 32'd0);
        chk({tag, "_mwr"}, {31'd0, mem_write_o}, 32'd0);
        chk({tag, "_maddr"}, mem_address_o, 32'd0);
        chk({tag, "_mwdata"}, mem_writedata_o, 32'd0);
        chk({tag, "_rdata0"}, rdata0_o, 32'd0);
        chk({tag, "_rdata1"}, rdata1_o, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] exp_grant;
        rst_ni = 1'b1; clk_enable_i = 1'b1;
        rd0_i = 0; wr0_i = 0; addr0_i = '0; wdata0_i = '0;
        rd1_i = 0; wr1_i = 0; addr1_i = '0; wdata1_i = '0;
        mem_readdata_i = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        #1 rst_ni = 1'b0;
        #1 chk_all_zero("rst");
        @(posedge clk_i); #1 rst_ni = 1'b1;

        // Write 0x54 to 0x8, then read it back.
        wr0_i = 1; addr0_i = 32'h8; wdata0_i = 32'h54;
        tick();
        chk("wr_issue_mwr", {31'd0, mem_write_o}, 32'd1);
        chk("wr_issue_mrd", {31'd0, mem_read_o}, 32'd0);
        chk("wr_issue_addr", mem_address_o, 32'h8);
        chk("wr_issue_wdata", mem_writedata_o, 32'h54);
        chk("wr_issue_busy", {31'd0, busy_o}, 32'd1);
        chk("wr_issue_ack0", {31'd0, ack0_o}, 32'd0);
        tick();
        chk("wr_done_ack0", {31'd0, ack0_o}, 32'd1);
        chk("wr_done_mwr", {31'd0, mem_write_o}, 32'd0);
        chk("wr_done_addr_hold", mem_address_o, 32'h8);
        wr0_i = 0;
        tick();
        chk("wr_idle_busy", {31'd0, busy_o}, 32'd0);
        rd0_i = 1;
        tick();
        chk("rd_issue_mrd", {31'd0, mem_read_o}, 32'd1);
        chk("rd_issue_mwr", {31'd0, mem_write_o}, 32'd0);
        tick();
        chk("rd_wait_mrd", {31'd0, mem_read_o}, 32'd0);
        chk("rd_wait_ack0", {31'd0, ack0_o}, 32'd0);
        tick();
        chk("rd_done_ack0", {31'd0, ack0_o}, 32'd1);
        chk("rd_done_rdata0", rdata0_o, 32'h54);
        rd0_i = 0;
        tick();
        chk("rd_idle_ack0", {31'd0, ack0_o}, 32'd0);
        chk("rd_idle_rdata0_hold", rdata0_o, 32'h54);

        // Fresh reset so req0 wins the contended grant.
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        rd0_i = 1; addr0_i = 32'h8; wr1_i = 1; addr1_i = 32'h4; wdata1_i = 32'hAB;
        tick();
        chk("cont_issue_mrd", {31'd0, mem_read_o}, 32'd1);
        chk("cont_issue_addr", mem_address_o, 32'h8);
        tick();
        tick();
        chk("cont_done_ack0", {31'd0, ack0_o}, 32'd1);
        chk("cont_done_ack1", {31'd0, ack1_o}, 32'd0);
        chk("cont_done_rdata0", rdata0_o, 32'h54);
        rd0_i = 0;
        tick();
        chk("cont_gap_ack1", {31'd0, ack1_o}, 32'd0);
        tick();
        chk("cont1_issue_mwr", {31'd0, mem_write_o}, 32'd1);
        chk("cont1_issue_addr", mem_address_o, 32'h4);
        chk("cont1_issue_wdata", mem_writedata_o, 32'hAB);
        tick();
        chk("cont1_done_ack1", {31'd0, ack1_o}, 32'd1);
        chk("cont1_done_ack0", {31'd0, ack0_o}, 32'd0);
        wr1_i = 0;
        tick();

        // Both requesters held for six transactions.
        wr0_i = 1; addr0_i = 32'h10; wdata0_i = 32'h11;
        wr1_i = 1; addr1_i = 32'h14; wdata1_i = 32'h22;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (!(ack0_o || ack1_o) && n < 20) begin
                tick();
                n++;
            end
            chk("rr_timeout", {31'd0, n < 20}, 32'd1);
`ifdef ARB_FIXED_PRIORITY_EN
            exp_grant = 32'd0;
`else
            exp_grant = i % 2;
`endif
            chk("rr_grant", {31'd0, ack1_o}, exp_grant);
            if (i == 5) begin
                wr0_i = 0;
                wr1_i = 0;
            end
            tick();
        end
        tick();

        // Freeze for five cycles while a read sits in ISSUE.
        rd1_i = 1; addr1_i = 32'h4;
        tick();
        chk("frz_issue_mrd", {31'd0, mem_read_o}, 32'd1);
        clk_enable_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("frz_hold_mrd", {31'd0, mem_read_o}, 32'd1);
            chk("frz_hold_ack1", {31'd0, ack1_o}, 32'd0);
        end
        clk_enable_i = 1'b1;
        tick();
        chk("frz_wait_mrd", {31'd0, mem_read_o}, 32'd0);
        chk("frz_wait_ack1", {31'd0, ack1_o}, 32'd0);
        tick();
        chk("frz_done_ack1", {31'd0, ack1_o}, 32'd1);
        chk("frz_done_rdata1", rdata1_o, 32'hAB);
        rd1_i = 0;
        tick();

        // rd1 and wr1 together behave as a write.
        rd1_i = 1; wr1_i = 1; addr1_i = 32'hC; wdata1_i = 32'h7;
        tick();
        chk("rw_issue_mwr", {31'd0, mem_write_o}, 32'd1);
        chk("rw_issue_mrd", {31'd0, mem_read_o}, 32'd0);
        chk("rw_issue_addr", mem_address_o, 32'hC);
        chk("rw_issue_wdata", mem_writedata_o, 32'h7);
        tick();
        chk("rw_done_ack1", {31'd0, ack1_o}, 32'd1);
        chk("rw_done_rdata1", rdata1_o, 32'hAB);
        chk("rw_mem_c", mem[3], 32'h7);
        rd1_i = 0; wr1_i = 0;
        tick();

        // Reset while in WAIT, then re-request.
        rd0_i = 1; addr0_i = 32'h8;
        tick();
        tick();
        chk("rw8_wait_busy", {31'd0, busy_o}, 32'd1);
        rst_ni = 1'b0;
        #1 chk_all_zero("rstw");
        tick();
        rst_ni = 1'b1;
        tick();
        chk("post_n1_ack0", {31'd0, ack0_o}, 32'd0);
        tick();
        chk("post_n2_ack0", {31'd0, ack0_o}, 32'd0);
        tick();
        chk("post_n3_ack0", {31'd0, ack0_o}, 32'd1);
        chk("post_n3_rdata0", rdata0_o, 32'h54);
        rd0_i = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
